// File: rtl/ex_hazard_fwd_ctrl.sv
// Execute-stage hazard and forwarding controller. Tracks in-flight destinations, stalls ID on
// load-use (or any EX/MEM RAW without forwarding), and registers operand-mux controls into EX.
module ex_hazard_fwd_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          FWD_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  id_opa_pc,
  input  logic                  id_opb_imm,
  input  logic                  flush,
  input  logic                  mem_stall,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic                  opa_sel,
  output logic                  opb_sel,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
);

  // WB is not tracked: the regfile writes through, so a WB producer is already visible at ID.
  logic                  ex_valid_q, ex_we_q, ex_load_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic                  mem_valid_q, mem_we_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic                  opa_q, opb_q;
  logic [1:0]            fwd_a_q, fwd_b_q;

  logic       ex_prod, mem_prod;
  logic       ex_m1, ex_m2, mem_m1, mem_m2;
  logic       load_use, raw, hz, issue;
  logic [1:0] fwd_a_d, fwd_b_d;

  assign ex_prod  = ex_valid_q && ex_we_q && (ex_rd_q != '0);
  assign mem_prod = mem_valid_q && mem_we_q && (mem_rd_q != '0);

  assign ex_m1  = ex_prod && (ex_rd_q == id_rs1) && id_use_rs1;
  assign ex_m2  = ex_prod && (ex_rd_q == id_rs2) && id_use_rs2;
  assign mem_m1 = mem_prod && (mem_rd_q == id_rs1) && id_use_rs1;
  assign mem_m2 = mem_prod && (mem_rd_q == id_rs2) && id_use_rs2;

  assign load_use = ex_load_q && (ex_m1 || ex_m2);
  assign raw      = ex_m1 || ex_m2 || mem_m1 || mem_m2;
  assign hz       = FWD_EN ? load_use : raw;

  assign id_stall = mem_stall || (id_valid && hz && !flush);
  assign issue    = id_valid && !hz && !flush;

  // Younger producer (EX) wins over MEM; a load in EX never reaches here since it stalls.
  always_comb begin
    fwd_a_d = 2'd0;
    fwd_b_d = 2'd0;
    if (FWD_EN) begin
      if (ex_m1)       fwd_a_d = 2'd1;
      else if (mem_m1) fwd_a_d = 2'd2;
      if (ex_m2)       fwd_b_d = 2'd1;
      else if (mem_m2) fwd_b_d = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_we_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_rd_q    <= '0;
      opa_q       <= 1'b0;
      opb_q       <= 1'b0;
      fwd_a_q     <= 2'd0;
      fwd_b_q     <= 2'd0;
    end else if (!mem_stall) begin
      mem_valid_q <= ex_valid_q;
      mem_we_q    <= ex_we_q;
      mem_rd_q    <= ex_rd_q;
      ex_valid_q  <= issue;
      ex_we_q     <= issue && id_rd_we;
      ex_load_q   <= issue && id_is_load;
      ex_rd_q     <= id_rd;
      opa_q       <= issue && id_opa_pc;
      opb_q       <= issue && id_opb_imm;
      fwd_a_q     <= issue ? fwd_a_d : 2'd0;
      fwd_b_q     <= issue ? fwd_b_d : 2'd0;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign opa_sel   = opa_q;
  assign opb_sel   = opb_q;
  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

endmodule
